pwm_capture: RTL

Measures an incoming PWM waveform and reports its period and high time in clock cycles, with the same 10-bit resolution as the PWM generator's counter. It is the receive end of the PWM path: a generated PWM (or an external one) is fed back into `pwm_in` for loop-back checking, duty readback and fault detection. It also flags an input that has stopped toggling, stuck high or stuck low.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_sync_edge.sv | 24 ++
 rtl/pwm_capture.sv | 118 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM path: counter width common to the
// generator and capture blocks, and the capture FSM state type.
package pwm_pkg;

  localparam int PWM_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } cap_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Three-flop synchronizer for an asynchronous input with a rising-edge strobe.
// Flops reset to 1 so a low must be seen before any rise is reported.
module pwm_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in clk cycles
// and flags an input that has stopped toggling (stuck high or stuck low).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         stuck_hi,
  output logic         stuck_lo
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  cap_state_t   r_state;
  cap_state_t   w_nextState;
  logic         w_level;
  logic         w_rise;
  logic         w_sat;
  logic         w_capture;
  logic         w_inStuck;
  logic [W-1:0] r_cntPer;
  logic [W-1:0] r_cntHi;

  pwm_sync_edge u_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_sat = (r_cntPer == MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A rise always takes priority over saturation, so a period of exactly MAX is still captured.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, MEASURE: begin
        if (w_rise) begin
          w_nextState = MEASURE;
        end else if (w_sat) begin
          w_nextState = STUCK;
        end
      end
      STUCK: begin
        if (w_rise) begin
          w_nextState = MEASURE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_inStuck = 1'b0;
    case (r_state)
      MEASURE: w_capture = w_rise;
      STUCK:   w_inStuck = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cntPer <= '0;
      r_cntHi  <= '0;
    end else if (w_rise) begin
      r_cntPer <= ONE;
      r_cntHi  <= ONE;
    end else if (w_inStuck) begin
      r_cntPer <= MAX;
      r_cntHi  <= MAX;
    end else begin
      if (r_cntPer != MAX) begin
        r_cntPer <= r_cntPer + ONE;
      end
      if (w_level && (r_cntHi != MAX)) begin
        r_cntHi <= r_cntHi + ONE;
      end
    end
  end

  // The rise that leaves STUCK ends an incomplete period, so it clears the flags without capturing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stuck_hi  <= 1'b0;
      stuck_lo  <= 1'b0;
    end else begin
      valid    <= w_capture;
      stuck_hi <= w_inStuck & ~w_rise & w_level;
      stuck_lo <= w_inStuck & ~w_rise & ~w_level;
      if (w_capture) begin
        period    <= r_cntPer;
        high_time <= r_cntHi;
      end
    end
  end

endmodule
